// File: rtl/button_cmd_gen.sv
// Debounced UP/DOWN button front end: one-cycle press pulses, hold-to-repeat, both-pressed lockout.
// States: IDLE wait for a press | DELAY wait for first repeat | REPEAT repeat cadence | LOCK both held
module button_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned REPEAT_DELAY    = 62500000,
  parameter int unsigned REPEAT_RATE     = 12500000
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic BTN_UP,
  input  logic BTN_DOWN,
  output logic UP,
  output logic DOWN,
  output logic UP_LVL,
  output logic DOWN_LVL
);

  localparam logic [31:0] DB_TC     = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DLY_LOAD  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LOAD = 32'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;

  // bit 0 is the up channel, bit 1 the down channel
  logic [1:0]  r_sync1, r_sync2, r_lvl, r_lvl_d;
  logic [31:0] r_db_cnt [2];

  state_t      r_state, w_state_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_up, r_down, w_up_nxt, w_down_nxt;
  logic [1:0]  w_rise;
  logic        w_dir_lvl, w_other_lvl;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_lvl       <= '0;
      r_lvl_d     <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= {BTN_DOWN, BTN_UP};
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_TC) begin
          r_lvl[i]    <= ~r_lvl[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign w_rise      = r_lvl & ~r_lvl_d;
  assign w_dir_lvl   = r_dir ? r_lvl[1] : r_lvl[0];
  assign w_other_lvl = r_dir ? r_lvl[0] : r_lvl[1];

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dir_nxt   = r_dir;
    w_up_nxt    = 1'b0;
    w_down_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (&r_lvl) begin
          w_state_nxt = S_LOCK;
        end else if (|w_rise) begin
          w_dir_nxt   = w_rise[1];
          w_up_nxt    = w_rise[0];
          w_down_nxt  = w_rise[1];
          w_timer_nxt = DLY_LOAD;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        // lockout beats release, release beats a timer expiry
        if (w_other_lvl) begin
          w_state_nxt = S_LOCK;
        end else if (!w_dir_lvl) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == '0) begin
          w_up_nxt    = ~r_dir;
          w_down_nxt  = r_dir;
          w_timer_nxt = RATE_LOAD;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      S_LOCK: begin
        if (r_lvl == 2'b00) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_dir   <= 1'b0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_dir   <= w_dir_nxt;
      r_up    <= w_up_nxt;
      r_down  <= w_down_nxt;
    end
  end

  assign UP       = r_up;
  assign DOWN     = r_down;
  assign UP_LVL   = r_lvl[0];
  assign DOWN_LVL = r_lvl[1];

endmodule
